// File: rtl/id_fetch_rx_pkg.sv
// Shared widths, opcodes and FSM encoding for the IF/ID receive path.
package id_fetch_rx_pkg;

  localparam int unsigned IF_TO_ID_BUS_W = 64;
  localparam int unsigned BR_BUS_W       = 33;

  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

endpackage

// File: rtl/id_fetch_rx_if.sv
// Fetch <-> decode bus: {pc, inst} forward, registered-redirect request back.
interface id_fetch_rx_if;
  import id_fetch_rx_pkg::*;

  logic [IF_TO_ID_BUS_W-1:0] if_to_id_bus;
  logic [BR_BUS_W-1:0]       br_bus;

  // Fetch side drives the slot and consumes the redirect.
  modport master (output if_to_id_bus, input br_bus);
  // Decode side consumes the slot and drives the redirect.
  modport slave  (input if_to_id_bus, output br_bus);
endinterface

// File: rtl/id_fetch_rx_jal_imm_gen.sv
// J-type immediate extract and sign-extend; shared with EX.
module jal_imm_gen (
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  // Reassemble imm[20:1] from its scattered J-type fields, bit 0 is always zero.
  always_comb begin
    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  end

endmodule

// File: rtl/id_fetch_rx.sv
// IF/ID pipeline register with stall/flush and early JAL redirect to fetch.
module id_fetch_rx
  import id_fetch_rx_pkg::*;
#(
  parameter bit          EARLY_JAL = 1'b1,
  parameter logic [31:0] NOP_INST  = NOP_INST_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  id_fetch_rx_if.slave        fetch,
  input  logic                stallD,
  input  logic                flushD,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_inst,
  output logic                id_valid,
  output logic                id_jal
);

  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        valid_r;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] imm;
  logic [31:0] target;
  logic        is_jal;
  logic        br_taken;
  logic        kill_next;

  logic [31:0] bus_pc;
  logic [31:0] bus_inst;

  assign bus_pc   = fetch.if_to_id_bus[63:32];
  assign bus_inst = fetch.if_to_id_bus[31:0];

  jal_imm_gen u_jal_imm_gen (
    .inst (inst_r),
    .imm  (imm)
  );

  // JAL decode and PC-relative target (wraps modulo 2^32).
  always_comb begin
    is_jal = valid_r && (inst_r[6:0] == OPC_JAL);
    target = pc_r + imm;
  end

  // IF/ID register: flush beats stall; the slot arriving while in KILL is latched invalid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_r    <= '0;
      inst_r  <= '0;
      valid_r <= 1'b0;
    end else if (flushD) begin
      pc_r    <= '0;
      inst_r  <= '0;
      valid_r <= 1'b0;
    end else if (!stallD) begin
      pc_r    <= bus_pc;
      inst_r  <= bus_inst;
      valid_r <= (bus_inst != '0) && !kill_next;
    end
  end

  // Kill-tracking state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: enter KILL on an issued redirect; leave on the next advancing edge or a flush.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:  if (br_taken)          state_nxt = KILL;
      KILL: if (flushD || !stallD) state_nxt = RUN;
      default:                     state_nxt = RUN;
    endcase
  end

  // Outputs: redirect only from RUN so a JAL held under stall fires exactly once, when it unstalls.
  always_comb begin
    br_taken  = EARLY_JAL && is_jal && (state == RUN) && !stallD && !flushD;
    kill_next = (state == KILL);
    fetch.br_bus = {br_taken, (br_taken ? target : 32'h0)};
    id_pc    = pc_r;
    id_inst  = valid_r ? inst_r : NOP_INST;
    id_valid = valid_r;
    id_jal   = is_jal;
  end

endmodule

// File: tb/tb_id_fetch_rx.sv
// Directed self-checking bench for id_fetch_rx.
module tb_id_fetch_rx;

  logic        clk;
  logic        rstn;
  logic        stallD;
  logic        flushD;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_jal;

  int unsigned total;
  int unsigned bad;

  id_fetch_rx_if fbus ();

  id_fetch_rx #(
    .EARLY_JAL (1'b1),
    .NOP_INST  (32'h0000_0013)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .fetch    (fbus.slave),
    .stallD   (stallD),
    .flushD   (flushD),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .id_jal   (id_jal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl);
    fbus.if_to_id_bus = {pc, inst};
    stallD = st;
    flushD = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    stallD = 1'b0;
    flushD = 1'b0;
    fbus.if_to_id_bus = {$urandom, $urandom};

    // Reset with garbage on the bus
    tick;
    fbus.if_to_id_bus = {$urandom, $urandom};
    tick;
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_inst",  64'(id_inst),  64'h13);
    chk("rst_pc",    64'(id_pc),    64'd0);
    chk("rst_br",    64'(fbus.br_bus), 64'd0);
    chk("rst_jal",   64'(id_jal),   64'd0);
    rstn = 1'b1;

    // First slot after reset, 1-cycle latency
    drive(32'h4, 32'h0050_0093, 1'b0, 1'b0);
    tick;
    chk("first_pc",    64'(id_pc),    64'h4);
    chk("first_valid", 64'(id_valid), 64'd1);
    chk("first_inst",  64'(id_inst),  64'h0050_0093);

    // Forward JAL +8 at 0x10
    drive(32'h10, 32'h0080_006F, 1'b0, 1'b0);
    tick;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    chk("fwd_br",  64'(fbus.br_bus), {31'd0, 1'b1, 32'h18});
    chk("fwd_jal", 64'(id_jal), 64'd1);
    tick;
    chk("fwd_br_once", 64'(fbus.br_bus), 64'd0);
    // wrong-path slot carries a JAL: must be killed, no redirect
    drive(32'h14, 32'h0080_006F, 1'b0, 1'b0);
    tick;
    chk("fwd_kill_valid", 64'(id_valid), 64'd0);
    chk("fwd_kill_pc",    64'(id_pc),    64'h14);
    chk("fwd_kill_inst",  64'(id_inst),  64'h13);
    chk("fwd_kill_jal",   64'(id_jal),   64'd0);
    chk("fwd_kill_br",    64'(fbus.br_bus), 64'd0);
    drive(32'h18, 32'h0020_0193, 1'b0, 1'b0);
    tick;
    chk("fwd_tgt_valid", 64'(id_valid), 64'd1);
    chk("fwd_tgt_pc",    64'(id_pc),    64'h18);

    // Backward wrap: jal -4 at pc 0
    drive(32'h0, 32'hFFDF_F06F, 1'b0, 1'b0);
    tick;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    chk("wrap_br", 64'(fbus.br_bus), {31'd0, 1'b1, 32'hFFFF_FFFC});
    tick;
    drive(32'h4, 32'h0010_0113, 1'b0, 1'b0);
    tick;
    chk("wrap_kill_valid", 64'(id_valid), 64'd0);
    drive(32'hFFFF_FFFC, 32'h0010_0113, 1'b0, 1'b0);
    tick;
    chk("wrap_tgt_valid", 64'(id_valid), 64'd1);
    chk("wrap_tgt_pc",    64'(id_pc),    64'hFFFF_FFFC);

    // JAL held under stall for 3 cycles
    drive(32'h100, 32'h0080_006F, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(32'h104, 32'h0010_0113, 1'b1, 1'b0);
      chk("stall_br", 64'(fbus.br_bus), 64'd0);
      tick;
      chk("stall_hold_pc", 64'(id_pc), 64'h100);
    end
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    chk("stall_release_br", 64'(fbus.br_bus), {31'd0, 1'b1, 32'h108});
    tick;
    chk("stall_br_once", 64'(fbus.br_bus), 64'd0);
    // stall while in KILL: kill must survive until the register advances
    drive(32'h104, 32'h0010_0113, 1'b1, 1'b0);
    tick;
    chk("kill_stall_pc", 64'(id_pc), 64'h0);
    drive(32'h104, 32'h0010_0113, 1'b0, 1'b0);
    tick;
    chk("kill_late_pc",    64'(id_pc),    64'h104);
    chk("kill_late_valid", 64'(id_valid), 64'd0);
    drive(32'h108, 32'h0030_0213, 1'b0, 1'b0);
    tick;
    chk("stall_tgt_valid", 64'(id_valid), 64'd1);

    // Flush in the same cycle as a JAL in ID
    drive(32'h200, 32'h0080_006F, 1'b0, 1'b0);
    tick;
    drive(32'h204, 32'h0010_0113, 1'b0, 1'b1);
    chk("flush_br",  64'(fbus.br_bus), 64'd0);
    chk("flush_jal", 64'(id_jal), 64'd1);
    tick;
    chk("flush_valid", 64'(id_valid), 64'd0);
    chk("flush_pc",    64'(id_pc),    64'd0);
    drive(32'h300, 32'h0050_0093, 1'b0, 1'b0);
    tick;
    chk("flush_next_valid", 64'(id_valid), 64'd1);
    chk("flush_next_pc",    64'(id_pc),    64'h300);

    // Fetch-flushed slot
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    tick;
    chk("zero_valid", 64'(id_valid), 64'd0);
    chk("zero_inst",  64'(id_inst),  64'h13);
    chk("zero_br",    64'(fbus.br_bus), 64'd0);

    // Reset with a pending kill drops it
    drive(32'h400, 32'h0080_006F, 1'b0, 1'b0);
    tick;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    tick;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(id_valid), 64'd0);
    chk("mid_rst_pc",    64'(id_pc),    64'd0);
    chk("mid_rst_br",    64'(fbus.br_bus), 64'd0);
    rstn = 1'b1;
    drive(32'h404, 32'h0010_0113, 1'b0, 1'b0);
    tick;
    chk("mid_rst_nokill", 64'(id_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_fetch_rx.md
Name: id_fetch_rx

Overview:
- Decode-side receiver of the fetch bus: IF/ID pipeline register with stall/flush, plus early JAL resolution.
- Latches {pc, inst} from the fetch stage and presents it to decode.
- Computes JAL targets in ID and drives the registered-redirect bus back to fetch.
- Kills the single wrong-path slot that fetch emits before a redirect lands.

Parameters:
- EARLY_JAL, 1, 1 = resolve JAL in ID and drive br_bus; 0 = br_bus held at 0, block is a pure IF/ID register.
- NOP_INST, 32'h0000_0013, instruction word presented on id_inst when the slot is invalid.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- if_to_id_bus  in  `if_to_id_bus_w (64)  {pc[31:0], inst[31:0]} from fetch; all-zero = fetch-flushed slot
- stallD  in  1  hazard unit: hold IF/ID contents (paired with bubbleF upstream)
- flushD  in  1  hazard unit: later-stage redirect, invalidate IF/ID and pending kill
- br_bus  out  `br_bus_w (33)  {br_taken, br_target[31:0]} to fetch
- id_pc  out  32  PC of instruction in ID
- id_inst  out  32  instruction in ID, NOP_INST when invalid
- id_valid  out  1  ID slot holds a real, non-killed instruction
- id_jal  out  1  valid JAL in ID (decode uses it for the link write)

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - Internal registers pc_r = 0, inst_r = 0, valid_r = 0; FSM = RUN.
  - Outputs: id_pc = 0, id_inst = NOP_INST, id_valid = 0, id_jal = 0, br_bus = 0.
- IF/ID register update on posedge clk, in priority order:
  - flushD: valid_r <= 0, pc_r/inst_r <= 0.
  - stallD: hold all.
  - otherwise: {pc_r, inst_r} <= if_to_id_bus; valid_r <= (inst != 0) && !kill_next.
  - Latency: fetch bus to id_* outputs is 1 cycle.
- Slot validity:
  - id_valid = valid_r.
  - id_inst = valid_r ? inst_r : NOP_INST.
  - id_pc = pc_r, always.
- JAL detect: is_jal = valid_r && inst_r[6:0] == 7'b1101111.
  - imm = sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} to 32 bits.
  - target = pc_r + imm, modulo 2^32 (wrap allowed, no error).
- br_bus is combinational from ID state:
  - br_taken = EARLY_JAL && is_jal && state == RUN && !stallD && !flushD.
  - br_target = target when br_taken, else 0.
- Redirect timing: fetch registers br_bus, so the new PC appears in fetch one cycle after br_taken. The instruction fetched in the br_taken cycle (pc+4) is wrong-path and arrives at ID the next cycle.
- FSM, 2 states:
  - RUN → KILL when br_taken and the register advances (not stalled).
  - In KILL, kill_next = 1 for the incoming slot, so that slot is latched with valid_r = 0.
  - KILL → RUN on the next non-stalled edge.
  - KILL + stallD: remain in KILL; kill is applied when the register finally advances.
  - KILL + flushD: → RUN (the flush already invalidates).
- Simultaneous events:
  - flushD beats stallD.
  - flushD beats a JAL redirect: br_taken = 0, no KILL entered.
  - A JAL held under stallD issues its redirect exactly once, in the first unstalled cycle.
- Back-to-back: a JAL in the killed slot is invalid, so no redirect is issued. A JAL at the redirect target is treated normally.
- Only JAL is resolved here. JALR and branches stay in EX and arrive via flushD plus fetch's own br_bus path.
- Reset asserted mid-operation: immediate return to reset values; a pending kill is dropped.

Decomposition:
- Shared package parameter.v holds:
  - `if_to_id_bus_w (64), `br_bus_w (33)
  - OPC_JAL = 7'b1101111
  - NOP_INST default
  - state encodings RUN = 1'b0, KILL = 1'b1
- One natural sub-module: jal_imm_gen (combinational J-type immediate extract + sign-extend), reusable by EX.
- FSM and register stay in id_fetch_rx.

Test Plan:
- Reset:
  - Stimulus: rstn low for 2 cycles with random bus input.
  - Response: id_valid = 0, id_inst = 32'h13, br_bus = 0; after release, bus {32'h4, 32'h00500093} shows id_pc = 4, id_valid = 1 one cycle later.
- Forward JAL:
  - Stimulus: {32'h10, 32'h0080006F} (jal x0, +8).
  - Response: next cycle br_bus = {1, 32'h18}, id_jal = 1; following slot {32'h14, x} latched with id_valid = 0; slot at 32'h18 is valid.
- Backward wrap:
  - Stimulus: pc 32'h0 with jal -4 (32'hFFDFF06F).
  - Response: br_target = 32'hFFFFFFFC.
- Stall on JAL:
  - Stimulus: JAL in ID with stallD = 1 for 3 cycles.
  - Response: br_taken = 0 throughout; br_taken = 1 exactly once in the first unstalled cycle; the subsequent slot is killed.
- Flush vs JAL:
  - Stimulus: JAL in ID with flushD = 1 in the same cycle.
  - Response: br_taken = 0; next cycle id_valid = 0, state RUN; the following slot is valid.
- Fetch-flushed slot:
  - Stimulus: if_to_id_bus = 64'h0.
  - Response: id_valid = 0, id_inst = 32'h13, no redirect.
